// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, FSM encoding, Rcon table and RotWord helper.
package aes_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned KEY_W      = 128;
    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned RND_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROTATE  = 2'd1,
        ST_RECOVER = 2'd2
    } state_e;

    // Rcon byte per round index; entry 0 is round 0 (01), entry 9 is round 9 (36)
    localparam logic [NUM_ROUNDS-1:0][7:0] RCON_TABLE = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    // Rcon lookup; indices past the table return zero
    function automatic logic [7:0] rcon_byte(input logic [RND_W-1:0] r);
        return (r < RND_W'(NUM_ROUNDS)) ? RCON_TABLE[r] : 8'h00;
    endfunction

    // One-byte rotate: byte 1 moves into byte 0, byte 0 into byte 3
    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] x);
        return {x[7:0], x[WORD_W-1:8]};
    endfunction

endpackage

// File: rtl/s_box.sv
// AES forward substitution box, purely combinational.
module s_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte_c
);

    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup, entry 0 is the leftmost byte
    assign out_byte_c = SBOX_TABLE[in_byte];

endmodule

// File: rtl/key_reversal.sv
// Inverse AES-128 key schedule: walks from the round-10 key back to the
// cipher key, two cycles per round key (rotate/substitute, then recover).
module key_reversal
    import aes_pkg::*;
#(
    parameter int unsigned numKeys = 11
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             startTransition,
    input  logic [KEY_W-1:0] lastRoundKeyInput,
    output logic [KEY_W-1:0] roundKeyOutput1,
    output logic [KEY_W-1:0] roundKeyOutput2,
    output logic [KEY_W-1:0] roundKeyOutput3,
    output logic [KEY_W-1:0] roundKeyOutput4,
    output logic [KEY_W-1:0] roundKeyOutput5,
    output logic [KEY_W-1:0] roundKeyOutput6,
    output logic [KEY_W-1:0] roundKeyOutput7,
    output logic [KEY_W-1:0] roundKeyOutput8,
    output logic [KEY_W-1:0] roundKeyOutput9,
    output logic [KEY_W-1:0] roundKeyOutput10,
    output logic [KEY_W-1:0] roundKeyOutput11,
    output logic             busy,
    output logic             done
);

    state_e              state;
    state_e              next_state;
    logic [RND_W-1:0]    r_idx;
    logic                armed;
    logic [KEY_W-1:0]    work_key;
    logic [WORD_W-1:0]   sbox_in;
    logic [WORD_W-1:0]   sbox_out;
    logic [KEY_W-1:0]    round_key [numKeys];
    logic [WORD_W-1:0]   w0_c, w1_c, w2_c, w3_c;
    logic [KEY_W-1:0]    prev_key_c;
    logic                start_ok_c;

    // The cycle that releases reset cannot start a run; armed opens the gate one edge later
    assign start_ok_c = (state == ST_IDLE) && startTransition && armed;

    // One s_box per byte of RotWord(w3)
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        s_box u_s_box (
            .in_byte   (sbox_in[8*g +: 8]),
            .out_byte_c(sbox_out[8*g +: 8])
        );
    end

    // Previous-round key from the working key and the registered substitution
    always_comb begin
        w3_c       = work_key[127:96] ^ work_key[95:64];
        w2_c       = work_key[95:64]  ^ work_key[63:32];
        w1_c       = work_key[63:32]  ^ work_key[31:0];
        w0_c       = work_key[31:0] ^ sbox_out ^ {24'h000000, rcon_byte(r_idx)};
        prev_key_c = {w3_c, w2_c, w1_c, w0_c};
    end

    // State register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; unused encodings fall back to IDLE
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (start_ok_c) next_state = ST_ROTATE;
            ST_ROTATE:  next_state = ST_RECOVER;
            ST_RECOVER: next_state = (r_idx == '0) ? ST_IDLE : ST_ROTATE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Datapath: round index, working key, s_box inputs, round-key bank, flags
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            armed    <= 1'b0;
            r_idx    <= '0;
            work_key <= '0;
            sbox_in  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int unsigned k = 0; k < numKeys; k++) round_key[k] <= '0;
        end else begin
            armed <= 1'b1;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok_c) begin
                        work_key <= lastRoundKeyInput;
                        r_idx    <= RND_W'(NUM_ROUNDS - 1);
                        busy     <= 1'b1;
                        for (int unsigned k = 0; k < numKeys; k++) begin
                            round_key[k] <= (k == numKeys - 1) ? lastRoundKeyInput : '0;
                        end
                    end
                end
                ST_ROTATE: begin
                    sbox_in <= rot_word(w3_c);
                end
                ST_RECOVER: begin
                    work_key <= prev_key_c;
                    for (int unsigned k = 0; k < numKeys; k++) begin
                        if (RND_W'(k) == r_idx) round_key[k] <= prev_key_c;
                    end
                    if (r_idx == '0) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        r_idx <= r_idx - RND_W'(1);
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

    assign roundKeyOutput1  = round_key[0];
    assign roundKeyOutput2  = round_key[1];
    assign roundKeyOutput3  = round_key[2];
    assign roundKeyOutput4  = round_key[3];
    assign roundKeyOutput5  = round_key[4];
    assign roundKeyOutput6  = round_key[5];
    assign roundKeyOutput7  = round_key[6];
    assign roundKeyOutput8  = round_key[7];
    assign roundKeyOutput9  = round_key[8];
    assign roundKeyOutput10 = round_key[9];
    assign roundKeyOutput11 = round_key[10];

endmodule

// File: tb/tb_key_reversal.sv
// Directed bench for key_reversal: FIPS-197 vector, reset behaviour,
// ignored starts, back-to-back runs, zero key and random round trips.
module tb_key_reversal;

    logic         clock;
    logic         resetN;
    logic         startTransition;
    logic [127:0] lastRoundKeyInput;
    logic [127:0] rk [11];
    logic         busy;
    logic         done;

    logic [127:0] exp_k [11];
    logic [7:0]   rcon_tb [10];
    int           checks   = 0;
    int           failures = 0;

    localparam logic [127:0] FIPS_K0  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] FIPS_K1  = 128'h05766c2a3939a323b12c548817fefaa0;
    localparam logic [127:0] FIPS_K10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;

    localparam logic [0:255][7:0] SBOX_TB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    key_reversal #(.numKeys(11)) dut (
        .clock            (clock),
        .resetN           (resetN),
        .startTransition  (startTransition),
        .lastRoundKeyInput(lastRoundKeyInput),
        .roundKeyOutput1  (rk[0]),
        .roundKeyOutput2  (rk[1]),
        .roundKeyOutput3  (rk[2]),
        .roundKeyOutput4  (rk[3]),
        .roundKeyOutput5  (rk[4]),
        .roundKeyOutput6  (rk[5]),
        .roundKeyOutput7  (rk[6]),
        .roundKeyOutput8  (rk[7]),
        .roundKeyOutput9  (rk[8]),
        .roundKeyOutput10 (rk[9]),
        .roundKeyOutput11 (rk[10]),
        .busy             (busy),
        .done             (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard time limit so the run can never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX_TB[x[31:24]], SBOX_TB[x[23:16]], SBOX_TB[x[15:8]], SBOX_TB[x[7:0]]};
    endfunction

    function automatic logic [31:0] rot(input logic [31:0] x);
        return {x[7:0], x[31:8]};
    endfunction

    // Forward key expansion (the key_creation reference) from the cipher key
    task automatic fwd_expand(input logic [127:0] k0);
        logic [31:0] w [4];
        exp_k[0] = k0;
        for (int i = 0; i < 4; i++) w[i] = k0[32*i +: 32];
        for (int r = 0; r < 10; r++) begin
            w[0] = sub_word(rot(w[3])) ^ w[0] ^ {24'h0, rcon_tb[r]};
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            exp_k[r+1] = {w[3], w[2], w[1], w[0]};
        end
    endtask

    // Software inverse schedule from the round-10 key
    task automatic inv_expand(input logic [127:0] k10);
        logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3;
        exp_k[10] = k10;
        for (int r = 9; r >= 0; r--) begin
            {a3, a2, a1, a0} = exp_k[r+1];
            b3 = a3 ^ a2;
            b2 = a2 ^ a1;
            b1 = a1 ^ a0;
            b0 = a0 ^ sub_word(rot(b3)) ^ {24'h0, rcon_tb[r]};
            exp_k[r] = {b3, b2, b1, b0};
        end
    endtask

    // One run against exp_k; optional start pulses at E5/E15, optional held start
    task automatic run(input logic [127:0] key, input bit pulse, input bit hold, input string tag);
        lastRoundKeyInput = key;
        startTransition   = 1'b1;
        tick();
        startTransition = hold;
        if (!hold) lastRoundKeyInput = ~key;
        chk({tag, "_busy_e0"}, 128'(busy), 128'(1'b1));
        chk({tag, "_rk11_e0"}, rk[10], key);
        for (int k = 0; k < 10; k++) chk($sformatf("%s_rk%0d_clear", tag, k + 1), rk[k], '0);
        for (int e = 1; e <= 20; e++) begin
            startTransition = hold || (pulse && (e == 5 || e == 15));
            tick();
            chk($sformatf("%s_done_e%0d", tag, e), 128'(done), 128'(e == 20));
            if (e % 2 == 0) begin
                chk($sformatf("%s_rk%0d_e%0d", tag, 11 - e / 2, e), rk[10 - e / 2], exp_k[10 - e / 2]);
            end
        end
        chk({tag, "_busy_e20"}, 128'(busy), 128'(1'b0));
        for (int k = 0; k < 11; k++) chk($sformatf("%s_final_rk%0d", tag, k + 1), rk[k], exp_k[k]);
    endtask

    initial begin
        bit seen_done;
        rcon_tb = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        resetN            = 1'b0;
        startTransition   = 1'b0;
        lastRoundKeyInput = '0;

        // Reset state
        tick();
        tick();
        for (int k = 0; k < 11; k++) chk($sformatf("reset_rk%0d", k + 1), rk[k], '0);
        chk("reset_busy", 128'(busy), 128'(1'b0));
        chk("reset_done", 128'(done), 128'(1'b0));

        // Start coinciding with reset release is ignored
        startTransition   = 1'b1;
        lastRoundKeyInput = FIPS_K10;
        @(posedge clock);
        resetN = 1'b1;
        #1;
        chk("release_start_busy", 128'(busy), 128'(1'b0));
        chk("release_start_rk11", rk[10], '0);
        startTransition = 1'b0;
        tick();
        tick();

        // FIPS-197 vector
        fwd_expand(FIPS_K0);
        run(FIPS_K10, 1'b0, 1'b0, "fips");
        chk("fips_cipher_key", rk[0], FIPS_K0);
        chk("fips_round1_key", rk[1], FIPS_K1);
        tick();
        chk("fips_done_e21", 128'(done), 128'(1'b0));
        repeat (5) tick();
        chk("fips_hold_rk1", rk[0], FIPS_K0);
        chk("fips_hold_rk11", rk[10], FIPS_K10);
        chk("fips_hold_busy", 128'(busy), 128'(1'b0));

        // Start pulses during a run are ignored
        run(FIPS_K10, 1'b1, 1'b0, "pulse");
        tick();
        chk("pulse_done_e21", 128'(done), 128'(1'b0));

        // Reset asserted at E7 clears everything at once
        lastRoundKeyInput = FIPS_K10;
        startTransition   = 1'b1;
        tick();
        startTransition = 1'b0;
        repeat (7) tick();
        resetN = 1'b0;
        #1;
        for (int k = 0; k < 11; k++) chk($sformatf("midreset_rk%0d", k + 1), rk[k], '0);
        chk("midreset_busy", 128'(busy), 128'(1'b0));
        chk("midreset_done", 128'(done), 128'(1'b0));
        tick();
        #3 resetN = 1'b1;
        seen_done = 1'b0;
        repeat (25) begin
            tick();
            seen_done = seen_done | done;
        end
        chk("midreset_no_done", 128'(seen_done), 128'(1'b0));
        chk("midreset_idle_busy", 128'(busy), 128'(1'b0));
        run(FIPS_K10, 1'b0, 1'b0, "after_reset");

        // Start held high: back-to-back runs, done at E20 and E41
        tick();
        run(FIPS_K10, 1'b0, 1'b1, "hold_a");
        run(FIPS_K10, 1'b0, 1'b1, "hold_b");
        startTransition = 1'b0;
        tick();
        chk("hold_done_e42", 128'(done), 128'(1'b0));
        chk("hold_busy_e42", 128'(busy), 128'(1'b0));

        // All-zero round-10 key
        inv_expand('0);
        run('0, 1'b0, 1'b0, "zero");
        tick();

        // Random round trips through the forward reference
        for (int n = 0; n < 200; n++) begin
            fwd_expand({$urandom(), $urandom(), $urandom(), $urandom()});
            run(exp_k[10], 1'b0, 1'b0, $sformatf("rand%0d", n));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_reversal.md
# key_reversal

Inverse AES-128 key schedule. From the round-10 (final) key, it regenerates all 11 round keys by running the expansion backwards, two clock cycles per key. It sits at the front of the decryption datapath: decryption consumes round keys last-first, so keys arrive in reverse order. Its outputs are bit-compatible with `key_creation`, so `key_reversal(key_creation(K).roundKeyOutput11)` reproduces every `key_creation` output.

## Interface
Parameters:
- `numKeys`, default 11: number of round keys. Fixed at 11 for AES-128; any other value is unsupported.

Ports:
- `clock`, input, 1: the single clock; all state changes on its rising edge.
- `resetN`, input, 1: reset, asynchronous, active-low.
- `startTransition`, input, 1: level-sampled in IDLE; 1 starts a run.
- `lastRoundKeyInput`, input, 128: round-10 key, sampled on the start edge.
- `roundKeyOutput1` … `roundKeyOutput11`, output, 128 each: round keys 0..10. `roundKeyOutput1` is the recovered cipher key.
- `busy`, output, 1: high while a run is in progress.
- `done`, output, 1: one-cycle pulse when `roundKeyOutput1` becomes valid.

## Operation
- Bus format, shared with `key_creation`:
  - key byte k sits at bits [8k+7:8k];
  - word j sits at [32j+31:32j];
  - Rcon occupies byte 0 of a word.
- Forward step, for reference: w0' = SubWord(RotWord(w3)) ^ w0 ^ Rcon[r], w1' = w1 ^ w0', and so on. RotWord(x) = {x[7:0], x[31:8]}.
- Inverse step, going from key r+1 (K') to key r (K):
  - w3 = w3' ^ w2'
  - w2 = w2' ^ w1'
  - w1 = w1' ^ w0'
  - w0 = w0' ^ SubWord(RotWord(w3)) ^ Rcon[r]
- Rcon[r] for r = 9 down to 0: 36, 1b, 80, 40, 20, 10, 08, 04, 02, 01 (hex, byte 0). An internal index `r` counts down from 9; Rcon is selected by `r`.
- States:
  - IDLE: if `startTransition` = 1, load the working key, set `roundKeyOutput11` = input, clear outputs 1..10 to 0, set r = 9, set `busy` = 1, go to ROTATE.
  - ROTATE: compute w3..w1 from the working key; register RotWord(w3) onto the four s_box inputs; go to RECOVER.
  - RECOVER: compute w0 from the s_box outputs; write {w3,w2,w1,w0} to `roundKeyOutput(r+1)` and to the working key.
    - If r = 0: set `done` = 1, `busy` = 0, go to IDLE.
    - Otherwise: r = r − 1, go to ROTATE.
  - Any illegal state goes to IDLE.
- `startTransition` is ignored while `busy` = 1.
- All XORs are 32-bit bitwise; there is no carry arithmetic.

## Timing
- Reset (asynchronous, `resetN` = 0): all 11 outputs = 0, `busy` = 0, `done` = 0, r = 0, state = IDLE.
- Edge E0: start accepted; `roundKeyOutput11` valid after E0.
- Key r becomes valid after edge E(2·(10−r)):
  - `roundKeyOutput10` after E2;
  - `roundKeyOutput1` after E20, with `done` high for the cycle E20..E21.
- Total latency: 20 cycles start-to-done.
- Back-to-back: `startTransition` held high gives a new start at E21. Outputs 1..10 read 0 from E21 until rewritten.
- Reset mid-run: outputs, state and `busy` clear immediately, and no `done` pulse is produced.
- A start arriving at the same edge as reset release is ignored; the first start can be accepted on the following edge.
- Outputs hold their values after `done` until the next start or reset.

## Structure
- Shared package `aes_pkg`:
  - Rcon table, 10 × 8-bit;
  - state encodings (IDLE, ROTATE, RECOVER);
  - RotWord helper.
- Sub-module: existing `s_box`, instantiated 4× (one per byte of RotWord(w3)). No new sub-module is needed.
- Outputs 1..11 are registers written by index decode of `r`.

## Test plan
- FIPS-197 vector: `lastRoundKeyInput` = 128'ha60c63b6c80c3fe18925eec9a8f914d0 → after E20, `roundKeyOutput1` = 128'h3c4fcf098815f7aba6d2ae2816157e2b and `roundKeyOutput2` = 128'h05766c2a3939a323b12c548817fefaa0; `done` is high for exactly one cycle at E20.
- Round trip: 200 random keys through `key_creation`, then feed its `roundKeyOutput11` to `key_reversal` → all 11 outputs match `key_creation` outputs bit-for-bit.
- Reset asserted at E7 of a run → all outputs 0 and `busy` = 0 immediately; no `done`; a new start after release gives the correct FIPS result.
- `startTransition` pulsed at E5 and E15 during a run → ignored; result and `done` timing unchanged.
- `startTransition` held high for 50 cycles with a fixed input → `done` pulses at E20 and E41; outputs 1..10 read 0 during E21..E22.
- All-zero input key → `roundKeyOutput1` matches the software model of the inverse schedule; `roundKeyOutput11` = 0.
